// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction fetcher feeding the instruction FIFO,
// credit-limited so no response can land in a full FIFO, with redirect flush.
module instr_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          FIFO_DEPTH      = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_data,
    input  logic        fifo_pop,
    output logic        fifo_flush
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc;
    logic [OW-1:0] outstanding, stale, in_flight_next;
    logic [CW-1:0] occ;
    logic [31:0]   credit_used;
    logic          req_fire, rsp_fire;

    // Live (non-stale) in-flight responses already own a FIFO slot.
    always_comb begin
        credit_used    = 32'(occ) + 32'(outstanding) - 32'(stale);
        imem_req_valid = fetch_en & ~rst & (32'(outstanding) < MAX_OUTSTANDING) & (credit_used < FIFO_DEPTH);
        imem_req_addr  = pc;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_fire       = imem_rsp_valid;
        fifo_wr_en     = rsp_fire & (stale == '0) & ~redirect_valid & ~rst;
        fifo_data      = imem_rsp_data;
        fifo_flush     = redirect_valid & ~rst;
        in_flight_next = outstanding + OW'(req_fire) - OW'(rsp_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            occ         <= '0;
        end else begin
            outstanding <= in_flight_next;
            if (redirect_valid) begin
                pc    <= redirect_pc & 32'hFFFF_FFFC;
                stale <= in_flight_next;
                occ   <= '0;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                stale <= stale - OW'(rsp_fire && stale != '0);
                occ   <= occ + CW'(fifo_wr_en) - CW'(fifo_pop && occ != '0);
            end
        end
    end
endmodule
